// File: rtl/if2id_buf_pkg.sv
// Shared constants and the entry type carried from fetch to decode.
// The decode stage sees a bubble as pc=0, inst=NOP, exp=0.
package if2id_buf_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] ZEROWORD = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] INST_NOP = XLEN'(32'h0000_0013);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            exp_flag;
   } if2id_entry_t;

   function automatic if2id_entry_t bubble_entry();
      if2id_entry_t e;
      e.pc       = ZEROWORD;
      e.inst     = INST_NOP;
      e.exp_flag = 1'b0;
      return e;
   endfunction

endpackage

// File: rtl/if2id_fifo_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous
// read port. Reset clears every entry to the bubble value.
module if2id_fifo_mem
   import if2id_buf_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [PTR_W-1:0]   waddr,
   input  if2id_entry_t       wdata,
   input  logic [PTR_W-1:0]   raddr,
   output if2id_entry_t       rdata
);

   if2id_entry_t mem_q [DEPTH];

   // Storage array write and reset clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= bubble_entry();
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/if2id_buf.sv
// In-order FIFO between fetch and decode. if_ready depends only on the
// registered occupancy, so no combinational ready path reaches fetch.
module if2id_buf
   import if2id_buf_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               if_valid,
   output logic               if_ready,
   input  logic [XLEN-1:0]    if_pc,
   input  logic [XLEN-1:0]    if_inst,
   input  logic               if_exp_flag,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [XLEN-1:0]    id_pc,
   output logic [XLEN-1:0]    id_inst,
   output logic               id_exp_flag,
   output logic [PTR_W:0]     buf_count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_s, pop_s;
   if2id_entry_t     wdata_s, head_s;

   assign if_ready  = (count_q != FULL_CNT);
   assign id_valid  = (count_q != (PTR_W+1)'(0));
   assign push_s    = if_valid & if_ready & ~flush;
   assign pop_s     = id_valid & id_ready & ~flush;
   assign buf_count = count_q;

   assign wdata_s.pc       = if_pc;
   assign wdata_s.inst     = if_inst;
   assign wdata_s.exp_flag = if_exp_flag;

   if2id_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (push_s),
      .waddr (wr_ptr_q),
      .wdata (wdata_s),
      .raddr (rd_ptr_q),
      .rdata (head_s)
   );

   // Pointer and occupancy next state; flush wins over push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         else        rd_ptr_d = rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is don't-care after a flush, so bubbles are forced here.
   always_comb begin
      id_pc       = ZEROWORD;
      id_inst     = INST_NOP;
      id_exp_flag = 1'b0;
      if (id_valid) begin
         id_pc       = head_s.pc;
         id_inst     = head_s.inst;
         id_exp_flag = head_s.exp_flag;
      end else begin
         id_pc       = ZEROWORD;
         id_inst     = INST_NOP;
         id_exp_flag = 1'b0;
      end
   end

endmodule

// File: tb/tb_if2id_buf.sv
// Self-checking bench for if2id_buf: directed scenarios plus random traffic,
// checked against a queue-based model of the fetch/decode buffer.
module tb_if2id_buf;

   localparam int DEPTH = 2;
   localparam int PTR_W = 1;
   localparam int OW    = 1 + 32 + 32 + 1 + 1 + PTR_W + 1;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exp;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             if_valid = 1'b0;
   logic             if_ready;
   logic [31:0]      if_pc = 32'h0;
   logic [31:0]      if_inst = 32'h0;
   logic             if_exp_flag = 1'b0;
   logic             id_valid;
   logic             id_ready = 1'b0;
   logic [31:0]      id_pc;
   logic [31:0]      id_inst;
   logic             id_exp_flag;
   logic [PTR_W:0]   buf_count;

   int   n_vec = 0;
   int   n_err = 0;
   ent_t mq[$];

   if2id_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_inst(if_inst), .if_exp_flag(if_exp_flag),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_inst(id_inst), .id_exp_flag(id_exp_flag),
      .buf_count(buf_count)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] dut_vec();
      return {id_valid, id_pc, id_inst, id_exp_flag, if_ready, buf_count};
   endfunction

   // Expected outputs derived only from the model queue's occupancy and head.
   function automatic logic [OW-1:0] model_vec();
      logic [PTR_W:0] c;
      c = (PTR_W+1)'(mq.size());
      if (mq.size() == 0)
         return {1'b0, 32'h0, 32'h0000_0013, 1'b0, 1'b1, c};
      else
         return {1'b1, mq[0].pc, mq[0].inst, mq[0].exp, (mq.size() != DEPTH), c};
   endfunction

   // Advance one clock: the model applies push/pop/flush from its own occupancy.
   task automatic tick();
      bit   acc, pp;
      ent_t e;
      acc = if_valid && (mq.size() < DEPTH) && !flush;
      pp  = (mq.size() != 0) && id_ready && !flush;
      e.pc = if_pc; e.inst = if_inst; e.exp = if_exp_flag;
      @(posedge clk);
      if (flush) mq.delete();
      else begin
         if (pp)  void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_vec++;
      if (dut_vec() !== model_vec()) begin
         n_err++; $display("FAIL reset_state: got %h want %h", dut_vec(), model_vec());
      end
      n_vec++;
      if (id_inst !== 32'h0000_0013 || if_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_nop: got inst=%h rdy=%b want inst=00000013 rdy=1", id_inst, if_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_push();
      id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h8000_0000; if_inst = 32'h0050_0093; if_exp_flag = 1'b0;
      tick();
      if_valid = 1'b0;
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8000_0000 || id_inst !== 32'h0050_0093) begin
         n_err++; $display("FAIL single_head: got v=%b pc=%h inst=%h want v=1 pc=80000000 inst=00500093", id_valid, id_pc, id_inst);
      end
      tick();
      n_vec++;
      if (dut_vec() !== model_vec() || buf_count !== 2'd0 || if_ready !== 1'b1) begin
         n_err++; $display("FAIL single_drain: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_stall_fill();
      id_ready = 1'b0; if_inst = 32'h0000_0033;
      for (int i = 0; i < 3; i++) begin
         if_valid = 1'b1; if_pc = 32'h0000_1000 + 32'(4 * i);
         n_vec++;
         if (if_ready !== (i < 2) || dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL stall_fill[%0d]: got %h want %h", i, dut_vec(), model_vec());
         end
         tick();
      end
      id_ready = 1'b1;
      n_vec++;
      if (id_pc !== 32'h0000_1000 || if_ready !== 1'b0) begin
         n_err++; $display("FAIL stall_head0: got pc=%h rdy=%b want pc=00001000 rdy=0", id_pc, if_ready);
      end
      tick();
      n_vec++;
      if (id_pc !== 32'h0000_1004 || if_ready !== 1'b1 || buf_count !== 2'd1) begin
         n_err++; $display("FAIL stall_head1: got pc=%h rdy=%b cnt=%0d want pc=00001004 rdy=1 cnt=1", id_pc, if_ready, buf_count);
      end
      tick();
      if_valid = 1'b0;
      n_vec++;
      if (dut_vec() !== model_vec() || id_pc !== 32'h0000_1008) begin
         n_err++; $display("FAIL stall_head2: got %h want %h", dut_vec(), model_vec());
      end
      tick();
   endtask

   task automatic test_stream();
      id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h0000_2000; if_inst = 32'h0000_0013;
      tick();
      for (int k = 0; k < 10; k++) begin
         n_vec++;
         if (id_pc !== 32'h0000_2000 + 32'(4 * k) || buf_count !== 2'd1 || dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL stream[%0d]: got pc=%h cnt=%0d want pc=%h cnt=1", k, id_pc, buf_count, 32'h0000_2000 + 32'(4 * k));
         end
         if_pc = 32'h0000_2000 + 32'(4 * (k + 1));
         tick();
      end
      if_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h0000_0093;
      if_pc = 32'h0000_3000; tick();
      if_pc = 32'h0000_3004; tick();
      flush = 1'b1; id_ready = 1'b1; if_pc = 32'h0000_DEAD;
      tick();
      flush = 1'b0; if_valid = 1'b0;
      n_vec++;
      if (id_valid !== 1'b0 || buf_count !== 2'd0 || id_inst !== 32'h0000_0013 || dut_vec() !== model_vec()) begin
         n_err++; $display("FAIL flush_empty: got %h want %h", dut_vec(), model_vec());
      end
      if_valid = 1'b1; if_pc = 32'h0000_0100; id_ready = 1'b0;
      tick();
      if_valid = 1'b0;
      n_vec++;
      if (id_pc !== 32'h0000_0100 || buf_count !== 2'd1) begin
         n_err++; $display("FAIL flush_after: got pc=%h cnt=%0d want pc=00000100 cnt=1", id_pc, buf_count);
      end
      id_ready = 1'b1;
      tick();
   endtask

   task automatic test_async_reset();
      id_ready = 1'b0; if_valid = 1'b1; if_inst = 32'h0000_00B3;
      if_pc = 32'h0000_4000; tick();
      if_pc = 32'h0000_4004; tick();
      if_valid = 1'b0;
      #3 rst = 1'b1;
      mq.delete();
      #1;
      n_vec++;
      if (id_valid !== 1'b0 || if_ready !== 1'b1 || buf_count !== 2'd0) begin
         n_err++; $display("FAIL async_rst: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", id_valid, if_ready, buf_count);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      if_valid = 1'b1; if_pc = 32'h0000_5000;
      tick();
      if_valid = 1'b0; id_ready = 1'b1;
      n_vec++;
      if (id_pc !== 32'h0000_5000 || dut_vec() !== model_vec()) begin
         n_err++; $display("FAIL rst_first: got %h want %h", dut_vec(), model_vec());
      end
      tick();
   endtask

   task automatic test_exception();
      id_ready = 1'b0; if_valid = 1'b1; if_pc = 32'h0000_6002; if_inst = 32'h0; if_exp_flag = 1'b1;
      tick();
      if_valid = 1'b0; if_exp_flag = 1'b0;
      n_vec++;
      if (id_exp_flag !== 1'b1 || id_inst !== 32'h0 || id_valid !== 1'b1) begin
         n_err++; $display("FAIL exc_head: got exp=%b inst=%h want exp=1 inst=00000000", id_exp_flag, id_inst);
      end
      id_ready = 1'b1;
      tick();
      n_vec++;
      if (id_exp_flag !== 1'b0 || id_inst !== 32'h0000_0013) begin
         n_err++; $display("FAIL exc_bubble: got exp=%b inst=%h want exp=0 inst=00000013", id_exp_flag, id_inst);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if_valid    = 1'($urandom_range(0, 1));
         id_ready    = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         if_pc       = $urandom;
         if_inst     = $urandom;
         if_exp_flag = ($urandom_range(0, 7) == 0);
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
         end
         tick();
      end
      flush = 1'b0; if_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_stall_fill();
      test_stream();
      test_flush();
      test_async_reset();
      test_exception();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
